// File: rtl/i2c_reg_hold_ctrl_if.sv
// i2c_reg_hold_ctrl_if: request/byte/hold-bank signals between the sequencer, I2C master and hold bank
interface i2c_reg_hold_ctrl_if;
    logic       start;
    logic       rd_req;
    logic       rd_ack;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [2:0] byte_count;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       bus_err;
    logic [5:0] load;
    logic [7:0] data_out;
    logic       busy;
    logic       frame_done;
    logic       frame_err;
    modport master (
        input  start, rd_ack, byte_valid, byte_in, bus_err,
        output rd_req, dev_addr, reg_addr, byte_count, load, data_out, busy, frame_done, frame_err
    );
    modport slave (
        output start, rd_ack, byte_valid, byte_in, bus_err,
        input  rd_req, dev_addr, reg_addr, byte_count, load, data_out, busy, frame_done, frame_err
    );
endinterface

// File: rtl/i2c_reg_hold_ctrl.sv
// i2c_reg_hold_ctrl: schedules 6-byte RTC burst reads and steers each byte into hold register 0..5
module i2c_reg_hold_ctrl #(
    parameter int         POLL_CYCLES    = 50_000_000,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [6:0] DEV_ADDR       = 7'h68,
    parameter logic [7:0] REG_ADDR       = 8'h00
) (
    input logic                   clk,
    input logic                   rst,
    i2c_reg_hold_ctrl_if.master   bus
);
    localparam int PW = $clog2(POLL_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [2:0] {IDLE, REQ, RECV, DONE, ERR} state_t;
    state_t nxt, state;
    logic [PW-1:0] poll_cnt;
    logic [TW-1:0] to_cnt;
    logic [2:0]    byte_idx;
    logic          poll_hit, to_hit, accept;
    assign bus.dev_addr   = DEV_ADDR;
    assign bus.reg_addr   = REG_ADDR;
    assign bus.byte_count = 3'd6;
    always_comb begin
        poll_hit = poll_cnt == PW'(POLL_CYCLES - 1);
        to_hit   = to_cnt == TW'(TIMEOUT_CYCLES - 1);
        accept   = state == RECV && bus.byte_valid && !bus.bus_err;
        nxt      = IDLE;
        case (state)
            IDLE:    nxt = (poll_hit || bus.start) ? REQ : IDLE;
            REQ:     nxt = bus.bus_err ? ERR : bus.rd_ack ? RECV : to_hit ? ERR : REQ;
            RECV:    nxt = bus.bus_err ? ERR : accept ? (byte_idx == 3'd5 ? DONE : RECV) : to_hit ? ERR : RECV;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end
    // every output is a flop fed from the next state so it lines up with the state it reports
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt       <= '0;
            to_cnt         <= '0;
            byte_idx       <= '0;
            bus.rd_req     <= 1'b0;
            bus.load       <= '0;
            bus.data_out   <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            poll_cnt       <= (state == IDLE && nxt == IDLE) ? poll_cnt + 1'b1 : '0;
            to_cnt         <= ((state == REQ || state == RECV) && nxt == state && !accept) ? to_cnt + 1'b1 : '0;
            byte_idx       <= (state == RECV && nxt == RECV) ? byte_idx + 3'(accept) : '0;
            bus.load       <= accept ? 6'b1 << byte_idx : '0;
            bus.data_out   <= accept ? bus.byte_in : bus.data_out;
            bus.rd_req     <= nxt == REQ;
            bus.busy       <= nxt == REQ || nxt == RECV;
            bus.frame_done <= nxt == DONE;
            bus.frame_err  <= nxt == ERR || (bus.frame_err && !(state == IDLE && nxt == REQ));
        end
    end
endmodule

// File: tb/tb_i2c_reg_hold_ctrl.sv
// tb_i2c_reg_hold_ctrl: directed sequence with hand-computed expectations (POLL=20, TIMEOUT=8)
module tb_i2c_reg_hold_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    i2c_reg_hold_ctrl_if bus();
    i2c_reg_hold_ctrl #(.POLL_CYCLES(20), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic start_ack();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.rd_ack = 1'b1;
        step();
        bus.rd_ack = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.start = 0; bus.rd_ack = 0; bus.byte_valid = 0; bus.byte_in = 0; bus.bus_err = 0;
        #1;
        check("rst_outs", {bus.rd_req, bus.load, bus.data_out, bus.busy, bus.frame_done, bus.frame_err}, 0);
        check("consts", {bus.dev_addr, bus.reg_addr, bus.byte_count}, {7'h68, 8'h00, 3'd6});
        step(); step();
        rst = 1'b1;
        // 1: automatic poll after 20 idle cycles, then REQ timeout with no rdAck
        repeat (19) step();
        check("poll_pre", {bus.rd_req, bus.load, bus.busy, bus.frame_done, bus.frame_err}, 0);
        step();
        check("poll_req", bus.rd_req, 1);
        check("poll_busy", bus.busy, 1);
        repeat (7) step();
        check("req_wait", {bus.rd_req, bus.frame_err}, 2'b10);
        step();
        check("req_timeout", {bus.rd_req, bus.busy, bus.frame_err}, 3'b001);
        step();
        bus.byte_valid = 1'b1; bus.byte_in = 8'hEE;
        step();
        bus.byte_valid = 1'b0;
        check("idle_byte_ignored", bus.load, 0);
        // 2: start, rdAck two cycles later, bytes with one-cycle gaps
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("start_req", bus.rd_req, 1);
        check("start_clr_err", bus.frame_err, 0);
        step();
        bus.rd_ack = 1'b1;
        step();
        bus.rd_ack = 1'b0;
        check("ack_recv", {bus.rd_req, bus.busy}, 2'b01);
        for (int i = 0; i < 6; i++) begin
            bus.byte_valid = 1'b1; bus.byte_in = 8'(8'h11 * (i + 1));
            step();
            bus.byte_valid = 1'b0;
            check("gap_load", bus.load, 32'(6'b1 << i));
            check("gap_data", bus.data_out, 32'(8'h11 * (i + 1)));
            check("gap_done", bus.frame_done, (i == 5) ? 1 : 0);
            if (i < 5) begin
                step();
                check("gap_idle_load", bus.load, 0);
            end
        end
        check("gap_end", {bus.busy, bus.frame_err}, 0);
        step();
        check("gap_done_pulse", {bus.frame_done, bus.load}, 0);
        // 3: back-to-back bytes
        start_ack();
        for (int i = 0; i < 6; i++) begin
            bus.byte_valid = 1'b1; bus.byte_in = 8'(8'hA0 + i);
            step();
            check("b2b_load", bus.load, 32'(6'b1 << i));
            check("b2b_data", bus.data_out, 32'(8'hA0 + i));
            check("b2b_done", bus.frame_done, (i == 5) ? 1 : 0);
        end
        bus.byte_valid = 1'b0;
        step();
        check("b2b_idle", {bus.rd_req, bus.busy, bus.frame_done, bus.load, bus.frame_err}, 0);
        // 4: busErr with the third byte
        start_ack();
        for (int i = 0; i < 3; i++) begin
            bus.byte_valid = 1'b1; bus.byte_in = 8'(8'h30 + i); bus.bus_err = (i == 2);
            step();
            check("err_load", bus.load, (i == 2) ? 0 : 32'(6'b1 << i));
        end
        bus.byte_valid = 1'b0; bus.bus_err = 1'b0;
        check("err_flag", {bus.busy, bus.frame_err, bus.data_out}, {1'b0, 1'b1, 8'h31});
        step();
        check("err_sticky", bus.frame_err, 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("err_clear", {bus.rd_req, bus.frame_err}, 2'b10);
        // 5: two bytes then silence
        bus.rd_ack = 1'b1;
        step();
        bus.rd_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.byte_valid = 1'b1; bus.byte_in = 8'(8'h50 + i);
            step();
        end
        bus.byte_valid = 1'b0;
        check("to_load2", bus.load, 6'h02);
        repeat (7) step();
        check("to_wait", {bus.busy, bus.frame_err}, 2'b10);
        step();
        check("to_err", {bus.busy, bus.frame_err, bus.frame_done}, 3'b010);
        step();
        // 6: asynchronous reset mid-frame
        start_ack();
        check("pre_rst_err", bus.frame_err, 0);
        for (int i = 0; i < 3; i++) begin
            bus.byte_valid = 1'b1; bus.byte_in = 8'(8'h70 + i);
            step();
        end
        bus.byte_valid = 1'b0;
        check("pre_rst_load", bus.load, 6'h04);
        #2 rst = 1'b0;
        #1;
        check("async_rst", {bus.rd_req, bus.load, bus.data_out, bus.busy, bus.frame_done, bus.frame_err}, 0);
        step(); step();
        rst = 1'b1;
        start_ack();
        for (int i = 0; i < 6; i++) begin
            bus.byte_valid = 1'b1; bus.byte_in = 8'(8'h5A + i);
            step();
            check("post_rst_load", bus.load, 32'(6'b1 << i));
            check("post_rst_data", bus.data_out, 32'(8'h5A + i));
        end
        bus.byte_valid = 1'b0;
        check("post_rst_done", {bus.frame_done, bus.frame_err}, 2'b10);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
